alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder; consumes its 5-bit Operation code and two 32-bit operands.
- Produces the ALU result and branch-compare flags.
- All non-multiply ops are single-cycle combinational.
- MUL (Operation[4]=1) runs on an iterative shift-add multiplier and asserts Stall to freeze PC/register writeback until the product is ready.

Parameters:
- XLEN, 32, operand/result width.
- MUL_STEP, 1, multiplier bits retired per BUSY cycle; must divide XLEN (1, 2, 4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- OpValid  in  1  decoded instruction present this cycle.
- Operation  in  5  ALU op code from the ALU control decoder.
- SrcA  in  XLEN  operand A (rs1 or PC).
- SrcB  in  XLEN  operand B (rs2 or immediate).
- Flush  in  1  kill any in-flight multiply.
- ALUResult  out  XLEN  result.
- Zero  out  1  ALUResult == 0.
- Lt  out  1  signed SrcA < SrcB.
- Ltu  out  1  unsigned SrcA < SrcB.
- Stall  out  1  hold PC and suppress writeback.
- MulDone  out  1  one-cycle pulse when the MUL result is valid.

Behaviour:
- Op encodings (Operation[3:0]): 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SLTU, 0110 SUB, 0111 SUB (unsigned-compare branches), 1000 SRL, 1010 SLT, 1100 SRA.
- Any other code: ALUResult=0.
- Operation[4]=1 means MUL; bits [3:0] are ignored in that case.
- Shifts use SrcB[4:0] only.
- ADD/SUB wrap modulo 2^XLEN.
- SLT/SLTU produce a zero-extended 0 or 1.
- Lt/Ltu are always computed from the current SrcA/SrcB, independent of Operation.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ALUResult is the combinational op result; Stall=0.
  - On OpValid && Operation[4] && !Flush: latch SrcA/SrcB, clear accumulator, count=0, set Stall=1 in the same cycle (combinational from the inputs), go to BUSY.
- BUSY:
  - Each cycle add MUL_STEP partial products and shift; count++.
  - Stall=1; ALUResult=0.
  - When count == XLEN/MUL_STEP-1, go to DONE.
- DONE:
  - ALUResult = low XLEN bits of the product (RISC-V MUL; signedness is irrelevant for the low half).
  - Stall=0, MulDone=1; unconditionally go to IDLE next cycle.
  - Live inputs are ignored this cycle, so the still-presented MUL does not restart.
- MUL latency: 1 issue cycle + XLEN/MUL_STEP BUSY cycles, then the DONE cycle. Default total is 33 Stall cycles, with the result in cycle 34.
- Flush in BUSY or DONE: next state IDLE, accumulator cleared, no MulDone pulse.
- Flush in IDLE at the same cycle as a MUL start: flush wins, no start.
- Reset (sync):
  - State IDLE, count=0, accumulator=0, latched operands=0.
  - While reset is high, Stall=0 and MulDone=0.
  - ALUResult/Zero/Lt/Ltu follow the combinational IDLE path.
- Reset mid-BUSY aborts the multiply; the next MUL issued after reset completes normally.
- OpValid=0 in IDLE: outputs still combinational, and a MUL is never started.

Optional Feature:
- Macro ALU_MUL_EARLY_TERM_EN.
- When defined: in BUSY, if the remaining unshifted multiplier bits are all zero, go to DONE on the next edge, skipping the rest of the iterations. The result is identical.
- When undefined: fixed XLEN/MUL_STEP BUSY cycles, data-independent latency.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the Operation encodings (ALU_AND … ALU_SRA, ALU_MUL_BIT=4);
  - the typedef enum logic [1:0] for exec_state_t {IDLE, BUSY, DONE};
  - XLEN default.
- One natural sub-module: seq_multiplier, containing the operand latches, accumulator, counter, early-termination logic and the done indication.
- alu_exec_unit keeps the combinational ALU, flags, FSM and output muxing.

Test Plan:
- ADD: SrcA=5, SrcB=7, Operation=00010, OpValid=1 -> ALUResult=12, Zero=0, Stall=0 in the same cycle.
- SUB: 3-3, op 00110 -> ALUResult=0, Zero=1. SLT: SrcA=0xFFFFFFFF, SrcB=1, op 01010 -> ALUResult=1, Lt=1, Ltu=0.
- SRA: SrcA=0x80000000, SrcB=36, op 01100 -> ALUResult=0xF8000000 (shift 4). SRL with the same inputs -> 0x08000000.
- MUL: SrcA=0xFFFFFFFF, SrcB=3, op 10010, held -> Stall=1 for 33 cycles, then DONE with ALUResult=0xFFFFFFFD, MulDone=1 for exactly one cycle; next cycle IDLE with no re-issue.
- Reset asserted at BUSY cycle 10 -> next cycle Stall=0, IDLE; reissue 6*7 -> 42 after full latency. Flush at BUSY cycle 5 -> IDLE, MulDone never pulses.
- With ALU_MUL_EARLY_TERM_EN: 7*2 -> DONE after 2 BUSY cycles, ALUResult=14. Without it: 33 Stall cycles, same result.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encodings, FSM state type and width default for the execute-stage ALU
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    localparam int ALU_MUL_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } exec_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier retiring MUL_STEP multiplier bits per step
// Optional early termination when ALU_MUL_EARLY_TERM_EN is defined.
module seq_multiplier #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] product,
    output logic            last
);

    localparam int STEPS = XLEN / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   count;

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (b_q[i]) acc_next = acc_next + (a_q << i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            count <= '0;
        end else if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            acc   <= '0;
            count <= '0;
        end else if (step) begin
            acc   <= acc_next;
            a_q   <= a_q << MUL_STEP;
            b_q   <= b_q >> MUL_STEP;
            count <= count + CW'(1);
        end
    end

    // Only the low XLEN bits are kept, so signedness of the operands does not matter.
    assign product = acc;

`ifdef ALU_MUL_EARLY_TERM_EN
    // Once the bits still waiting behind the current step are zero, no further partial products remain.
    assign last = (count == LAST_CNT) || ((b_q >> MUL_STEP) == '0);
`else
    assign last = (count == LAST_CNT);
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with branch flags and a stalling sequential MUL
// Multiplier early termination is enabled by defining ALU_MUL_EARLY_TERM_EN.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = ALU_XLEN,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            OpValid,
    input  logic [4:0]      Operation,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Lt,
    output logic            Ltu,
    output logic            Stall,
    output logic            MulDone
);

    exec_state_t     state;
    exec_state_t     state_next;
    logic [XLEN-1:0] alu_comb;
    logic [XLEN-1:0] product;
    logic [4:0]      shamt;
    logic            mul_start;
    logic            mul_last;

    assign shamt = SrcB[4:0];
    assign Lt    = $signed(SrcA) < $signed(SrcB);
    assign Ltu   = SrcA < SrcB;

    always_comb begin
        alu_comb = '0;
        case (Operation[3:0])
            ALU_AND:            alu_comb = SrcA & SrcB;
            ALU_OR:             alu_comb = SrcA | SrcB;
            ALU_ADD:            alu_comb = SrcA + SrcB;
            ALU_XOR:            alu_comb = SrcA ^ SrcB;
            ALU_SLL:            alu_comb = SrcA << shamt;
            ALU_SLTU:           alu_comb = {{(XLEN-1){1'b0}}, Ltu};
            ALU_SUB, ALU_SUBU:  alu_comb = SrcA - SrcB;
            ALU_SRL:            alu_comb = SrcA >> shamt;
            ALU_SLT:            alu_comb = {{(XLEN-1){1'b0}}, Lt};
            ALU_SRA:            alu_comb = XLEN'($signed(SrcA) >>> shamt);
            default:            alu_comb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        Stall      = 1'b0;
        MulDone    = 1'b0;
        case (state)
            IDLE: begin
                if (OpValid && Operation[ALU_MUL_BIT] && !Flush) begin
                    mul_start  = 1'b1;
                    Stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (Flush)         state_next = IDLE;
                else if (mul_last) state_next = DONE;
            end
            // Live inputs are ignored here so a still-presented MUL does not reissue.
            DONE: begin
                MulDone    = !Flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            mul_start = 1'b0;
            Stall     = 1'b0;
            MulDone   = 1'b0;
        end
    end

    always_comb begin
        ALUResult = alu_comb;
        if (!reset) begin
            case (state)
                BUSY:    ALUResult = '0;
                DONE:    ALUResult = product;
                default: ALUResult = alu_comb;
            endcase
        end
    end

    assign Zero = (ALUResult == '0);

    seq_multiplier #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .flush   (Flush && (state != IDLE)),
        .start   (mul_start),
        .step    ((state == BUSY) && !Flush),
        .op_a    (SrcA),
        .op_b    (SrcB),
        .product (product),
        .last    (mul_last)
    );

endmodule
